// File: rtl/handshake_delay_line_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | handshake_delay_line_if : token/config bundle for the matched delay line |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface handshake_delay_line_if #(
  parameter int WIDTH = 32,
  parameter int DLY_W = 4
);
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [DLY_W-1:0] delay_cfg;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DLY_W-1:0] active_delay;
  logic [DLY_W-1:0] inflight;
  logic             busy;

  modport master (
    output en, in_valid, in_data, delay_cfg,
    input  out_valid, out_data, active_delay, inflight, busy
  );

  modport slave (
    input  en, in_valid, in_data, delay_cfg,
    output out_valid, out_data, active_delay, inflight, busy
  );
endinterface
`default_nettype wire

// File: rtl/handshake_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | handshake_delay_line : programmable bundled-data delay with kill gate    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module handshake_delay_line #(
  parameter int WIDTH     = 32,
  parameter int MAX_DELAY = 10,
  parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  handshake_delay_line_if.slave  hs
);

  localparam logic [DLY_W-1:0] C_MAX_DLY = DLY_W'(MAX_DELAY);
  localparam logic [DLY_W-1:0] C_ONE     = DLY_W'(1);

  logic [MAX_DELAY-1:0] vld_q;
  logic [WIDTH-1:0]     data_q [MAX_DELAY];
  logic [DLY_W-1:0]     active_delay_q, active_delay_d;
  logic [DLY_W-1:0]     inflight_q, inflight_d;
  logic [DLY_W-1:0]     cfg_clamped;
  logic                 tap_vld;
  logic [WIDTH-1:0]     tap_data;
  logic                 accept;
  logic                 emit;
  logic                 busy;

  assign accept = hs.in_valid & hs.en;
  assign emit   = tap_vld & hs.en;
  assign busy   = (inflight_q != '0);

  always_comb begin
    cfg_clamped = hs.delay_cfg;
    if (hs.delay_cfg == '0) begin
      cfg_clamped = C_ONE;
    end else if (hs.delay_cfg > C_MAX_DLY) begin
      cfg_clamped = C_MAX_DLY;
    end
  end

  always_comb begin
    tap_vld  = 1'b0;
    tap_data = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (active_delay_q == DLY_W'(k + 1)) begin
        tap_vld  = vld_q[k];
        tap_data = data_q[k];
      end
    end
  end

  always_comb begin
    active_delay_d = busy ? active_delay_q : cfg_clamped;
    inflight_d     = inflight_q + {{(DLY_W-1){1'b0}}, accept}
                                - {{(DLY_W-1){1'b0}}, emit};
    if (!hs.en) begin
      inflight_d = '0;
    end
  end

  // Valids are dropped past the tap so a later, longer delay never
  // resurrects a token that was already emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int k = 1; k < MAX_DELAY; k++) begin
        vld_q[k] <= vld_q[k-1] & hs.en & (DLY_W'(k) < active_delay_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    data_q[0] <= hs.in_data;
    for (int k = 1; k < MAX_DELAY; k++) begin
      data_q[k] <= data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_delay_q <= C_MAX_DLY;
      inflight_q     <= '0;
    end else begin
      active_delay_q <= active_delay_d;
      inflight_q     <= inflight_d;
    end
  end

  assign hs.out_valid    = emit;
  assign hs.out_data     = emit ? tap_data : '0;
  assign hs.active_delay = active_delay_q;
  assign hs.inflight     = inflight_q;
  assign hs.busy         = busy;

endmodule
`default_nettype wire

// File: tb/tb_handshake_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_handshake_delay_line : directed + random bench with a due-time model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_handshake_delay_line;

  localparam int WIDTH     = 32;
  localparam int MAX_DELAY = 10;
  localparam int DLY_W     = $clog2(MAX_DELAY + 1);

  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } tok_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  handshake_delay_line_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) hs ();

  handshake_delay_line #(
    .WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hs (hs)
  );

  int   total = 0;
  int   bad   = 0;
  tok_t q[$];
  int   m_ad  = MAX_DELAY;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int clamp(input int c);
    if (c < 1) return 1;
    if (c > MAX_DELAY) return MAX_DELAY;
    return c;
  endfunction

  // Every accepted token is scheduled to appear at accept cycle + delay.
  task automatic step(input logic r, input logic e, input logic v,
                      input logic [WIDTH-1:0] d, input int cfg, input bit do_chk);
    logic             exp_v;
    logic [WIDTH-1:0] exp_d;
    bit               was_busy;
    rst          = r;
    hs.en        = e;
    hs.in_valid  = v;
    hs.in_data   = d;
    hs.delay_cfg = DLY_W'(cfg);
    @(negedge clk);
    exp_v = e && (q.size() > 0) && (q[0].due == cyc);
    exp_d = exp_v ? q[0].data : '0;
    if (do_chk) begin
      check("out_valid",    32'(hs.out_valid),    32'(exp_v));
      check("out_data",     hs.out_data,          exp_d);
      check("active_delay", 32'(hs.active_delay), 32'(m_ad));
      check("inflight",     32'(hs.inflight),     32'(q.size()));
      check("busy",         32'(hs.busy),         32'(q.size() != 0));
    end
    @(posedge clk);
    was_busy = (q.size() != 0);
    if (r) begin
      q.delete();
      m_ad = MAX_DELAY;
    end else begin
      if (!was_busy) m_ad = clamp(cfg);
      if (!e) begin
        q.delete();
      end else begin
        if (exp_v) void'(q.pop_front());
        if (v) q.push_back('{due: cyc + m_ad, data: d});
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input int cfg);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, cfg, 1'b1);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input int cfg);
    step(1'b0, 1'b1, 1'b1, d, cfg, 1'b1);
  endtask

  initial begin
    int cfg;
    int dens;

    step(1'b1, 1'b1, 1'b0, '0, 3, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 3, 1'b1);

    idle(2, 3);
    send(32'hA5, 3);
    idle(6, 3);

    for (int i = 1; i <= 8; i++) send(32'(i), 4);
    idle(8, 4);

    send(32'h11, 0);
    idle(3, 0);
    send(32'h22, 15);
    idle(12, 15);

    idle(1, 6);
    send(32'h33, 6);
    idle(8, 2);
    send(32'h44, 2);
    idle(4, 2);

    idle(1, 4);
    for (int i = 0; i < 3; i++) send(32'h50 + 32'(i), 4);
    step(1'b0, 1'b0, 1'b1, 32'hDEAD, 4, 1'b1);
    idle(6, 4);
    send(32'h66, 4);
    idle(6, 4);

    idle(1, 8);
    for (int i = 0; i < 5; i++) send(32'h70 + 32'(i), 8);
    step(1'b1, 1'b1, 1'b0, '0, 8, 1'b1);
    idle(12, 8);

    cfg  = 5;
    dens = 2;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) dens = int'($urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) cfg = int'($urandom_range(0, 15));
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 24) != 0,
           $urandom_range(0, 3) < dens,
           $urandom, cfg, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/handshake_delay_line.md
# handshake_delay_line

Clocked, parametrised successor to the fixed gated-AND delay chain. Provides a bundled-data matched delay: each accepted token (valid + data) reappears exactly `d` cycles later, where `d` is runtime-programmable up to `MAX_DELAY`. An enable input kills all in-flight tokens, mirroring the gating input of the original chain. It sits between a producer stage's request/data and the consumer stage in the pipelined datapath, and in benches as a configurable latency model.

## Interface
- `WIDTH`, 32: data bits carried with each token.
- `MAX_DELAY`, 10: number of shift stages; maximum programmable latency in cycles (≥1).
- `DLY_W`, `$clog2(MAX_DELAY+1)`: width of delay and count fields.
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  gate; low kills every in-flight token.
- `in_valid`  in  1  token present this cycle.
- `in_data`  in  WIDTH  token payload.
- `delay_cfg`  in  DLY_W  requested latency in cycles.
- `out_valid`  out  1  delayed token present.
- `out_data`  out  WIDTH  delayed payload, 0 when `out_valid` is low.
- `active_delay`  out  DLY_W  latency currently applied.
- `inflight`  out  DLY_W  tokens accepted but not yet emitted.
- `busy`  out  1  `inflight != 0`.

## Operation
- Storage: `MAX_DELAY` stages of {valid, data}. Stage 0 loads {`in_valid & en`, `in_data`}; stage k loads stage k-1 with valid ANDed with `en`.
- Tap: `out_valid = stage[active_delay-1].valid & en`; `out_data = out_valid ? stage[active_delay-1].data : 0`. Stages beyond the tap are don't-care and never drive outputs.
- Clamping: `delay_cfg` of 0 is treated as 1; values above `MAX_DELAY` are treated as `MAX_DELAY`.
- Delay reload: on any edge where `busy` is 0 (sampled before the edge), `active_delay <= clamp(delay_cfg)`. While `busy` is 1, `delay_cfg` is ignored; no token is ever re-timed mid-flight. A token accepted on the reload edge uses the new delay.
- Counter: on each edge, `inflight <= inflight + (in_valid & en) - out_valid`. If `en` is 0, `inflight <= 0` regardless.
- Kill: `en` low clears all stage valids on the next edge and forces `out_valid` low combinationally in the same cycle. `in_valid` is ignored while `en` is low. Data contents are not cleared.
- Throughput: one token per cycle, back-to-back, with no bubbles. Token order is preserved.
- Arithmetic: `inflight` never exceeds `active_delay`, so it never exceeds `MAX_DELAY` and `DLY_W` cannot overflow.

## Timing
- Reset (rst high at an edge): all stage valids are 0 and `inflight` is 0. `active_delay = MAX_DELAY`, `out_valid = 0`, `out_data = 0`, `busy = 0`. The first edge after reset deassertion loads `clamp(delay_cfg)`.
- Latency: `in_valid` high in cycle n gives `out_valid` high in cycle n+d, with the same data. With d=1, output appears the cycle after acceptance.
- Simultaneous accept and emit in one cycle: `inflight` is unchanged.
- Reset mid-flight: all tokens are discarded and none is emitted afterwards.
- `en` dropped for one cycle mid-flight: tokens are lost. Tokens accepted after `en` returns have normal latency.
- A `delay_cfg` change while busy takes effect on the first edge where `busy` is 0.

## Test plan
- Reset, then `delay_cfg`=3, single token 0xA5 in cycle 5 -> `out_valid` only in cycle 8 with `out_data`=0xA5. `inflight` is 1 for cycles 6–8 and 0 after.
- `delay_cfg`=4, tokens 1..8 every cycle from cycle 10 -> outputs 1..8 in cycles 14–21 with no gaps. `inflight` peaks at 4.
- `delay_cfg`=0 and then 15 (MAX_DELAY=10) -> `active_delay` reads 1 and then 10. Measured latencies are 1 and 10.
- Token in flight with d=6; `delay_cfg` changed to 2 at the second cycle -> token emerges at 6 cycles. The next token (sent after idle) takes 2 cycles.
- Three tokens in flight, `en` low for 1 cycle -> `out_valid` is 0 in that cycle and never asserts for those tokens. `inflight`=0. A new token afterwards has normal latency.
- `rst` pulsed while 5 tokens are in flight -> all outputs go to their reset values the next cycle. No stale `out_valid` ever follows.
